// File: rtl/pu_requant_mul_pipe.sv
// rtl/pu_requant_mul_pipe.sv - multi-channel 3-stage requant pipeline: multiply, rounding shift, saturate
// Optional ReLU clamp on the output stage when PU_REQUANT_RELU_EN is defined.
module pu_requant_mul_pipe #(
    parameter int CH        = 8,
    parameter int INPUT_WD1 = 20,
    parameter int INPUT_WD2 = 16,
    parameter int SHIFT_WD  = 6,
    parameter int OUTPUT_WD = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [CH*INPUT_WD1-1:0]   op1_i,
    input  logic [CH*INPUT_WD2-1:0]   op2_i,
    input  logic [CH*SHIFT_WD-1:0]    shift_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [CH*OUTPUT_WD-1:0]   data_o
);

    localparam int PW = INPUT_WD1 + INPUT_WD2 + 1;
    localparam int RW = PW + 1;

    localparam logic signed [OUTPUT_WD-1:0] OUT_MAX = {1'b0, {(OUTPUT_WD-1){1'b1}}};
    localparam logic signed [OUTPUT_WD-1:0] OUT_MIN = {1'b1, {(OUTPUT_WD-1){1'b0}}};
    localparam logic signed [RW-1:0]        R_MAX   = {{(RW-OUTPUT_WD){1'b0}}, OUT_MAX};
    localparam logic signed [RW-1:0]        R_MIN   = {{(RW-OUTPUT_WD){1'b1}}, OUT_MIN};

    logic                        stall;
    logic                        advance;
    logic                        s1_valid;
    logic                        s2_valid;
    logic                        s3_valid;

    logic signed [PW-1:0]        s1_prod  [CH];
    logic [SHIFT_WD-1:0]         s1_shift [CH];
    logic signed [RW-1:0]        s2_r     [CH];

    logic signed [PW-1:0]        prod_d   [CH];
    logic signed [RW-1:0]        sum_d    [CH];
    logic signed [RW-1:0]        r_d      [CH];
    logic signed [OUTPUT_WD-1:0] sat_d    [CH];

    // All stages move together; only a blocked output beat freezes the pipe.
    assign stall       = s3_valid & ~out_ready_i;
    assign advance     = ~stall;
    assign in_ready_o  = advance;
    assign out_valid_o = s3_valid;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            prod_d[k] = PW'($signed(op1_i[k*INPUT_WD1 +: INPUT_WD1]))
                      * PW'($signed({1'b0, op2_i[k*INPUT_WD2 +: INPUT_WD2]}));
        end
    end

    // Shifts of PW or more always round to zero: |prod| < 2^(PW-1) <= rounding term.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            sum_d[k] = RW'(s1_prod[k]) + (RW'(1) << (s1_shift[k] - SHIFT_WD'(1)));
            if (s1_shift[k] == '0) begin
                r_d[k] = RW'(s1_prod[k]);
            end else if (int'(s1_shift[k]) >= PW) begin
                r_d[k] = '0;
            end else begin
                r_d[k] = sum_d[k] >>> s1_shift[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            if (s2_r[k] > R_MAX) begin
                sat_d[k] = OUT_MAX;
            end else if (s2_r[k] < R_MIN) begin
                sat_d[k] = OUT_MIN;
            end else begin
                sat_d[k] = s2_r[k][OUTPUT_WD-1:0];
            end
`ifdef PU_REQUANT_RELU_EN
            if (sat_d[k][OUTPUT_WD-1]) begin
                sat_d[k] = '0;
            end
`endif
        end
    end

    // Data registers load only behind a valid beat; bubbles leave stale data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            data_o   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid_i;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            for (int k = 0; k < CH; k++) begin
                if (in_valid_i) begin
                    s1_prod[k]  <= prod_d[k];
                    s1_shift[k] <= shift_i[k*SHIFT_WD +: SHIFT_WD];
                end
                if (s1_valid) begin
                    s2_r[k] <= r_d[k];
                end
                if (s2_valid) begin
                    data_o[k*OUTPUT_WD +: OUTPUT_WD] <= sat_d[k];
                end
            end
        end
    end

endmodule
